// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM duty sequencer: state encoding,
// period length and the saturating duty step.
package pwm_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   function automatic int unsigned pwm_period(input int unsigned r);
      return 32'd1 << r;
   endfunction

   // Move duty toward target by at most step; never overshoots or wraps.
   function automatic int unsigned sat_step(input int unsigned duty,
                                            input int unsigned target,
                                            input int unsigned step);
      int unsigned diff;
      int unsigned inc;
      diff = (target > duty) ? (target - duty) : (duty - target);
      inc  = (diff < step) ? diff : step;
      return (target > duty) ? (duty + inc) : (duty - inc);
   endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Host-side target handshake of the PWM duty sequencer.
interface pwm_duty_sequencer_if #(
   parameter int unsigned R = 4
);
   logic [R-1:0] tgt_duty;
   logic         tgt_valid;
   logic         tgt_ready;

   modport master (output tgt_duty, output tgt_valid, input  tgt_ready);
   modport slave  (input  tgt_duty, input  tgt_valid, output tgt_ready);
endinterface

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter, frozen (not cleared) while en is low so it
// stays aligned with the PWM block; flags the last clock of each period.
module pwm_period_counter
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned R = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic period_tick
);

   localparam int unsigned LAST = pwm_period(R) - 1;

   logic [R-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + R'(1);
      end
   end

   assign period_tick = en && (cnt == R'(LAST));

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Accepts a target duty from the host and ramps the PWM duty toward it in
// bounded steps, changing duty only at period boundaries.
module pwm_duty_sequencer
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned R     = 4,
   parameter int unsigned STEP  = 1,
   parameter int unsigned DWELL = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   pwm_duty_sequencer_if.slave  tgt,
   output logic [R-1:0]         duty,
   output logic                 period_tick,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned DW = $clog2(DWELL + 1);

   state_t        state;
   logic [R-1:0]  target;
   logic [DW-1:0] dwell;
   logic [R-1:0]  nxt_duty_c;

   pwm_period_counter #(.R(R)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .period_tick (period_tick)
   );

   assign nxt_duty_c    = R'(sat_step(32'(duty), 32'(target), STEP));
   assign tgt.tgt_ready = (state == ST_IDLE);
   assign busy          = (state == ST_RAMP);

   // Handshake, dwell counting and duty stepping; done pulses on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         duty   <= '0;
         target <= '0;
         dwell  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tgt.tgt_valid) begin
                  target <= tgt.tgt_duty;
                  dwell  <= '0;
                  if (tgt.tgt_duty == duty) begin
                     done <= 1'b1;
                  end else begin
                     state <= ST_RAMP;
                  end
               end
            end
            ST_RAMP: begin
               if (period_tick) begin
                  if (dwell != DW'(DWELL - 1)) begin
                     dwell <= dwell + DW'(1);
                  end else begin
                     dwell <= '0;
                     duty  <= nxt_duty_c;
                     if (nxt_duty_c == target) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: offered targets are queued by the
// stimulus; the monitor expands each into a step schedule and checks outputs.
module tb_pwm_duty_sequencer;

   localparam int unsigned R     = 4;
   localparam int unsigned STEP  = 3;
   localparam int unsigned DWELL = 2;
   localparam int          PER   = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b0;
   logic [R-1:0] duty;
   logic         period_tick;
   logic         busy;
   logic         done;

   pwm_duty_sequencer_if #(.R(R)) tif ();

   pwm_duty_sequencer #(.R(R), .STEP(STEP), .DWELL(DWELL)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .tgt         (tif.slave),
      .duty        (duty),
      .period_tick (period_tick),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int duty;
      int tick_at;
   } step_t;

   int    sb_q[$];
   step_t pend[$];
   int    m_duty     = 0;
   int    m_cnt      = 0;
   int    m_ticks    = 0;
   bit    m_idle     = 1'b1;
   bit    m_done_due = 1'b0;
   bit    prev_tick  = 1'b0;
   bit    rand_en    = 1'b0;

   bit    exp_done;
   bit    tick_now;
   int    t, d, k, diff;
   step_t s;

   // Reference model: enabled-cycle count gives ticks; each accepted target
   // expands into the list of duties it should pass through and when.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         pend.delete();
         m_duty = 0; m_cnt = 0; m_ticks = 0;
         m_idle = 1'b1; m_done_due = 1'b0; prev_tick = 1'b0;
         chk("rst_duty",  int'(duty), 0);
         chk("rst_busy",  int'(busy), 0);
         chk("rst_ready", int'(tif.tgt_ready), 1);
         chk("rst_done",  int'(done), 0);
      end else begin
         exp_done   = m_done_due;
         m_done_due = 1'b0;
         if (pend.size() > 0 && prev_tick && pend[0].tick_at == m_ticks) begin
            s      = pend.pop_front();
            m_duty = s.duty;
            if (pend.size() == 0) begin
               m_idle   = 1'b1;
               exp_done = 1'b1;
            end
         end
         chk("duty",  int'(duty), m_duty);
         chk("done",  int'(done), int'(exp_done));
         chk("busy",  int'(busy), int'(!m_idle));
         chk("ready", int'(tif.tgt_ready), int'(m_idle));

         tick_now = en && ((m_cnt % PER) == PER - 1);
         chk("period_tick", int'(period_tick), int'(tick_now));
         if (en) m_cnt++;
         if (tick_now) m_ticks++;
         prev_tick = tick_now;

         if (m_idle && tif.tgt_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_accept", 1, 0);
            end else begin
               t = sb_q.pop_front();
               chk("offered_tgt", int'(tif.tgt_duty), t);
               d = m_duty;
               k = 1;
               if (t == d) begin
                  m_done_due = 1'b1;
               end else begin
                  m_idle = 1'b0;
                  while (d != t) begin
                     diff = (t > d) ? t - d : d - t;
                     if (diff > int'(STEP)) diff = int'(STEP);
                     d = (t > d) ? d + diff : d - diff;
                     pend.push_back('{d, m_ticks + int'(DWELL) * k});
                     k++;
                  end
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (m_idle) return;
         if (rand_en) en = ($urandom_range(0, 7) != 0);
         cyc(1);
      end
      chk("idle_timeout", 0, 1);
   endtask

   task automatic send(input int tv);
      wait_idle(4000);
      en = 1'b1;
      sb_q.push_back(tv);
      tif.tgt_valid = 1'b1;
      tif.tgt_duty  = R'(tv);
      cyc(1);
      tif.tgt_valid = 1'b0;
   endtask

   initial begin
      tif.tgt_valid = 1'b0;
      tif.tgt_duty  = '0;
      #1 rst = 1'b0;
      #12;
      chk("init_duty",  int'(duty), 0);
      chk("init_ready", int'(tif.tgt_ready), 1);
      chk("init_busy",  int'(busy), 0);
      chk("init_done",  int'(done), 0);
      chk("init_tick",  int'(period_tick), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      en  = 1'b1;
      cyc(40);

      // Ramp up, saturating ramp down, equal target.
      send(4);
      send(8);
      send(1);
      send(1);
      send(0);

      // Full-scale ramp with an ignored mid-ramp offer, then an en freeze.
      send(15);
      cyc(3);
      tif.tgt_valid = 1'b1;
      tif.tgt_duty  = '0;
      cyc(20);
      tif.tgt_valid = 1'b0;
      cyc(30);
      en = 1'b0;
      cyc(40);
      en = 1'b1;
      send(15);
      send(0);

      // Randomized targets with random en drops.
      rand_en = 1'b1;
      repeat (25) begin
         if ($urandom_range(0, 5) == 0) send(m_idle ? m_duty : 0);
         else send(int'($urandom_range(0, 15)));
      end
      wait_idle(4000);
      rand_en = 1'b0;
      en = 1'b1;

      // Async reset mid-ramp.
      send(0);
      send(12);
      for (int i = 0; i < 2000 && m_duty != 6; i++) cyc(1);
      chk("reached_6", m_duty, 6);
      #2 rst = 1'b0;
      #1;
      chk("arst_duty",  int'(duty), 0);
      chk("arst_busy",  int'(busy), 0);
      chk("arst_ready", int'(tif.tgt_ready), 1);
      chk("arst_done",  int'(done), 0);
      cyc(3);
      rst = 1'b1;
      cyc(100);
      send(5);
      wait_idle(4000);
      cyc(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
